// File: rtl/tournament_bpu.sv
// Tournament branch predictor: local-history and gshare components picked by a per-PC
// chooser, with a direct-mapped BTB, speculative global history and branch/miss counters.
module tournament_bpu #(
   parameter int ADDR_W    = 32,
   parameter int GHR_W     = 10,
   parameter int LHT_IDX_W = 8,
   parameter int LHR_W     = 10,
   parameter int CHS_IDX_W = 10,
   parameter int BTB_IDX_W = 6,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   output logic [GHR_W-1:0]  pred_ghr,
   output logic [LHR_W-1:0]  pred_lhr,
   output logic              pred_local,
   output logic              pred_global,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic [GHR_W-1:0]  upd_ghr,
   input  logic [LHR_W-1:0]  upd_lhr,
   input  logic              upd_pred_local,
   input  logic              upd_pred_global,
   input  logic              upd_mispredict,
   output logic [CNT_W-1:0]  cnt_branch,
   output logic [CNT_W-1:0]  cnt_miss
);
   localparam int LHT_N  = 1 << LHT_IDX_W;
   localparam int LPHT_N = 1 << LHR_W;
   localparam int GPHT_N = 1 << GHR_W;
   localparam int CHS_N  = 1 << CHS_IDX_W;
   localparam int BTB_N  = 1 << BTB_IDX_W;
   localparam int TAG_W  = ADDR_W - BTB_IDX_W - 2;

   logic [GHR_W-1:0]  ghr;
   logic [LHR_W-1:0]  lht     [LHT_N];
   logic [1:0]        lpht    [LPHT_N];
   logic [1:0]        gpht    [GPHT_N];
   logic [1:0]        chs     [CHS_N];
   logic              btb_v   [BTB_N];
   logic [TAG_W-1:0]  btb_tag [BTB_N];
   logic [ADDR_W-1:0] btb_tgt [BTB_N];

   logic [LHT_IDX_W-1:0] p_lidx, u_lidx;
   logic [CHS_IDX_W-1:0] p_cidx, u_cidx;
   logic [BTB_IDX_W-1:0] p_bidx, u_bidx;
   logic [GHR_W-1:0]     u_gidx;
   logic                 unused_pc_lsb;

   logic              raw_hit, raw_taken, raw_local, raw_global;
   logic [LHR_W-1:0]  raw_lhr;
   logic [ADDR_W-1:0] raw_target;

   assign p_lidx = if_pc[LHT_IDX_W+1:2];
   assign p_cidx = if_pc[CHS_IDX_W+1:2];
   assign p_bidx = if_pc[BTB_IDX_W+1:2];
   assign u_lidx = upd_pc[LHT_IDX_W+1:2];
   assign u_cidx = upd_pc[CHS_IDX_W+1:2];
   assign u_bidx = upd_pc[BTB_IDX_W+1:2];
   assign u_gidx = upd_ghr ^ upd_pc[GHR_W+1:2];
   assign unused_pc_lsb = ^{if_pc[1:0], upd_pc[1:0]};

   function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
      if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
      else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
   endfunction

   always_comb begin
      raw_hit    = btb_v[p_bidx] && (btb_tag[p_bidx] == if_pc[ADDR_W-1:BTB_IDX_W+2]);
      raw_lhr    = lht[p_lidx];
      raw_local  = lpht[raw_lhr][1];
      raw_global = gpht[ghr ^ if_pc[GHR_W+1:2]][1];
      raw_taken  = raw_hit && (chs[p_cidx][1] ? raw_global : raw_local);
      raw_target = raw_taken ? btb_tgt[p_bidx] : if_pc + ADDR_W'(4);
   end

   // Outputs are held at zero for the whole time reset is asserted.
   always_comb begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = '0;
      pred_ghr    = '0;
      pred_lhr    = '0;
      pred_local  = 1'b0;
      pred_global = 1'b0;
      if (rst) begin
         pred_hit    = raw_hit;
         pred_taken  = raw_taken;
         pred_target = raw_target;
         pred_ghr    = ghr;
         pred_lhr    = raw_lhr;
         pred_local  = raw_local;
         pred_global = raw_global;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr        <= '0;
         cnt_branch <= '0;
         cnt_miss   <= '0;
         for (int i = 0; i < LHT_N; i++)  lht[i]   <= '0;
         for (int i = 0; i < LPHT_N; i++) lpht[i]  <= 2'b01;
         for (int i = 0; i < GPHT_N; i++) gpht[i]  <= 2'b01;
         for (int i = 0; i < CHS_N; i++)  chs[i]   <= 2'b01;
         for (int i = 0; i < BTB_N; i++)  btb_v[i] <= 1'b0;
      end else begin
         // A resolved misprediction rebuilds history from the returned snapshot.
         if (upd_valid && upd_mispredict)
            ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
         else if (if_valid && raw_hit)
            ghr <= {ghr[GHR_W-2:0], raw_taken};

         if (upd_valid) begin
            cnt_branch     <= cnt_branch + CNT_W'(1);
            lpht[upd_lhr]  <= sat2(lpht[upd_lhr], upd_taken);
            gpht[u_gidx]   <= sat2(gpht[u_gidx], upd_taken);
            lht[u_lidx]    <= {upd_lhr[LHR_W-2:0], upd_taken};
            if (upd_mispredict)
               cnt_miss <= cnt_miss + CNT_W'(1);
            if (upd_pred_local != upd_pred_global)
               chs[u_cidx] <= sat2(chs[u_cidx], upd_pred_global == upd_taken);
            if (upd_taken)
               btb_v[u_bidx] <= 1'b1;
         end
      end
   end

   // Tag/target payload is qualified by btb_v, so it needs no reset.
   always_ff @(posedge clk) begin
      if (upd_valid && upd_taken) begin
         btb_tag[u_bidx] <= upd_pc[ADDR_W-1:BTB_IDX_W+2];
         btb_tgt[u_bidx] <= upd_target;
      end
   end

endmodule

// File: tb/tb_tournament_bpu.sv
// Bench for tournament_bpu: reference-model tracking every cycle, a vector table,
// directed corner sequences and a randomized run.
module tb_tournament_bpu;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_hit, pred_taken, pred_local, pred_global;
   logic [31:0] pred_target;
   logic [9:0]  pred_ghr, pred_lhr;
   logic        upd_valid, upd_taken, upd_pred_local, upd_pred_global, upd_mispredict;
   logic [31:0] upd_pc, upd_target;
   logic [9:0]  upd_ghr, upd_lhr;
   logic [31:0] cnt_branch, cnt_miss;

   tournament_bpu dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .pred_ghr(pred_ghr), .pred_lhr(pred_lhr), .pred_local(pred_local),
      .pred_global(pred_global), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
      .upd_lhr(upd_lhr), .upd_pred_local(upd_pred_local),
      .upd_pred_global(upd_pred_global), .upd_mispredict(upd_mispredict),
      .cnt_branch(cnt_branch), .cnt_miss(cnt_miss)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: plain integer tables indexed by word address.
   int unsigned m_lht [256];
   int unsigned m_lpht [1024];
   int unsigned m_gpht [1024];
   int unsigned m_chs [1024];
   bit          m_bv [64];
   int unsigned m_btag [64];
   int unsigned m_btgt [64];
   int unsigned m_ghr, m_cb, m_cm;
   bit          e_hit, e_taken, e_local, e_global;
   int unsigned e_target, e_lhr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic int unsigned sat(input int unsigned c, input bit up);
      if (up) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_lht[i] = 0;
      for (int i = 0; i < 1024; i++) begin
         m_lpht[i] = 1; m_gpht[i] = 1; m_chs[i] = 1;
      end
      for (int i = 0; i < 64; i++) m_bv[i] = 0;
      m_ghr = 0; m_cb = 0; m_cm = 0;
   endtask

   task automatic model_predict();
      int unsigned w, b;
      w = if_pc >> 2;
      b = w % 64;
      e_lhr    = m_lht[w % 256];
      e_local  = m_lpht[e_lhr] >= 2;
      e_global = m_gpht[(m_ghr ^ w) % 1024] >= 2;
      e_hit    = m_bv[b] && (m_btag[b] == (if_pc >> 8));
      e_taken  = e_hit && ((m_chs[w % 1024] >= 2) ? e_global : e_local);
      e_target = e_taken ? m_btgt[b] : if_pc + 32'd4;
   endtask

   task automatic model_update();
      int unsigned w;
      w = upd_pc >> 2;
      if (upd_valid && upd_mispredict) m_ghr = ((upd_ghr << 1) | upd_taken) % 1024;
      else if (if_valid && e_hit)      m_ghr = ((m_ghr << 1) | e_taken) % 1024;
      if (upd_valid) begin
         m_cb++;
         if (upd_mispredict) m_cm++;
         m_lpht[upd_lhr] = sat(m_lpht[upd_lhr], upd_taken);
         m_gpht[(upd_ghr ^ w) % 1024] = sat(m_gpht[(upd_ghr ^ w) % 1024], upd_taken);
         m_lht[w % 256] = ((upd_lhr << 1) | upd_taken) % 1024;
         if (upd_pred_local != upd_pred_global)
            m_chs[w % 1024] = sat(m_chs[w % 1024], upd_pred_global == upd_taken);
         if (upd_taken) begin
            m_bv[w % 64] = 1; m_btag[w % 64] = upd_pc >> 8; m_btgt[w % 64] = upd_target;
         end
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycle();
      #1;
      model_predict();
      chk("m_hit", pred_hit, e_hit);
      chk("m_taken", pred_taken, e_taken);
      chk("m_target", pred_target, e_target);
      chk("m_ghr", pred_ghr, m_ghr);
      chk("m_lhr", pred_lhr, e_lhr);
      chk("m_local", pred_local, e_local);
      chk("m_global", pred_global, e_global);
      chk("m_cnt_branch", cnt_branch, m_cb);
      chk("m_cnt_miss", cnt_miss, m_cm);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      if_valid = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
      upd_ghr = 0; upd_lhr = 0; upd_pred_local = 0; upd_pred_global = 0; upd_mispredict = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_hit"}, pred_hit, 0);
      chk({tag, "_taken"}, pred_taken, 0);
      chk({tag, "_target"}, pred_target, 0);
      chk({tag, "_ghr"}, pred_ghr, 0);
      chk({tag, "_lhr"}, pred_lhr, 0);
      chk({tag, "_local"}, pred_local, 0);
      chk({tag, "_global"}, pred_global, 0);
      chk({tag, "_cnt_branch"}, cnt_branch, 0);
      chk({tag, "_cnt_miss"}, cnt_miss, 0);
   endtask

   // Reset pulse strictly between edges (entered at a falling edge).
   task automatic pulse_reset();
      rst = 0;
      #1;
      check_all_zero("pulse_rst");
      model_reset();
      rst = 1;
      #1;
   endtask

   function automatic logic [31:0] rnd_pc();
      return 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
   endfunction

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic [9:0]  ughr, ulhr;
      logic        upl, upg, umis;
      logic        x_hit, x_taken;
      logic [31:0] x_target;
      logic [9:0]  x_ghr, x_lhr;
      logic        x_local, x_global;
   } vec_t;

   vec_t vecs [6];
   bit   s_taken, s_l, s_g;
   logic [9:0] s_ghr, s_lhr;
   int   misses;

   initial begin
      vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   10'h0, 10'h0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h104, 10'h0, 10'h0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'h300, 1'b1, 32'h100, 1'b1, 32'h200, 10'h0, 10'h0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 32'h304, 10'h0, 10'h0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   10'h0, 10'h0, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 32'h104, 10'h1, 10'h1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   10'h0, 10'h0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h204, 10'h1, 10'h0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   10'h0, 10'h0, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 32'h104, 10'h1, 10'h1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 32'h104, 1'b0, 32'h0,   1'b0, 32'h0,   10'h0, 10'h0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h108, 10'h2, 10'h0, 1'b1, 1'b0};

      rst = 0;
      idle_inputs();
      if_pc = 32'h100;
      #12;
      check_all_zero("rst_hold");
      model_reset();
      @(negedge clk);
      rst = 1;
      #1;
      chk("rel_hit", pred_hit, 0);
      chk("rel_taken", pred_taken, 0);
      chk("rel_target", pred_target, 32'h104);
      chk("rel_ghr", pred_ghr, 0);
      chk("rel_cnt_branch", cnt_branch, 0);

      foreach (vecs[i]) begin
         if_valid = vecs[i].iv; if_pc = vecs[i].pc;
         upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
         upd_target = vecs[i].utgt; upd_ghr = vecs[i].ughr; upd_lhr = vecs[i].ulhr;
         upd_pred_local = vecs[i].upl; upd_pred_global = vecs[i].upg;
         upd_mispredict = vecs[i].umis;
         #1;
         chk($sformatf("vec%0d_hit", i), pred_hit, vecs[i].x_hit);
         chk($sformatf("vec%0d_taken", i), pred_taken, vecs[i].x_taken);
         chk($sformatf("vec%0d_target", i), pred_target, vecs[i].x_target);
         chk($sformatf("vec%0d_ghr", i), pred_ghr, vecs[i].x_ghr);
         chk($sformatf("vec%0d_lhr", i), pred_lhr, vecs[i].x_lhr);
         chk($sformatf("vec%0d_local", i), pred_local, vecs[i].x_local);
         chk($sformatf("vec%0d_global", i), pred_global, vecs[i].x_global);
         cycle();
      end

      idle_inputs();
      pulse_reset();

      misses = 0;
      for (int it = 0; it < 12; it++) begin
         idle_inputs();
         if_valid = 1; if_pc = 32'h100;
         #1;
         s_ghr = pred_ghr; s_lhr = pred_lhr; s_l = pred_local; s_g = pred_global;
         s_taken = pred_taken;
         cycle();
         idle_inputs();
         upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h200;
         upd_ghr = s_ghr; upd_lhr = s_lhr; upd_pred_local = s_l; upd_pred_global = s_g;
         upd_mispredict = !s_taken;
         if (!s_taken) misses++;
         cycle();
      end
      idle_inputs();
      if_pc = 32'h100;
      #1;
      chk("train_hit", pred_hit, 1);
      chk("train_taken", pred_taken, 1);
      chk("train_target", pred_target, 32'h200);
      chk("train_cnt_branch", cnt_branch, 12);
      chk("train_cnt_miss", cnt_miss, misses);
      cycle();

      if_valid = 1; if_pc = 32'h100;
      upd_valid = 1; upd_mispredict = 1; upd_ghr = 10'h155; upd_taken = 0;
      upd_pc = 32'h400; upd_lhr = 10'h3; upd_pred_local = 1; upd_pred_global = 0;
      #1;
      chk("restore_pre_hit", pred_hit, 1);
      cycle();
      idle_inputs();
      if_pc = 32'h100;
      #1;
      chk("restore_ghr", pred_ghr, 10'h2AA);

      s_ghr = pred_ghr; s_lhr = pred_lhr;
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         if_pc = 32'h100;
         upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h200;
         upd_ghr = s_ghr; upd_lhr = s_lhr; upd_pred_local = 1; upd_pred_global = 1;
         cycle();
      end
      idle_inputs();
      if_pc = 32'h100;
      #1;
      chk("sat_local", pred_local, 1);
      chk("sat_global", pred_global, 1);
      chk("sat_taken", pred_taken, 1);
      chk("sat_lhr", pred_lhr, 10'h3FF);

      if_pc = 32'h200;
      #1;
      chk("alias_hit", pred_hit, 0);
      chk("alias_target", pred_target, 32'h204);
      cycle();

      pulse_reset();
      if_pc = 32'h100;
      #1;
      chk("post_rst_hit", pred_hit, 0);
      chk("post_rst_target", pred_target, 32'h104);
      cycle();

      for (int r = 0; r < 500; r++) begin
         if_valid = 1'($urandom_range(0, 1));
         if_pc = rnd_pc();
         upd_valid = ($urandom_range(0, 3) != 0);
         upd_pc = rnd_pc();
         upd_taken = 1'($urandom_range(0, 1));
         upd_target = $urandom;
         upd_ghr = 10'($urandom);
         upd_lhr = ($urandom_range(0, 1) != 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
         upd_pred_local = 1'($urandom_range(0, 1));
         upd_pred_global = 1'($urandom_range(0, 1));
         upd_mispredict = ($urandom_range(0, 3) == 0);
         cycle();
         if (r == 250) pulse_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/tournament_bpu.md
Name: tournament_bpu

Overview:
- Parametrised successor to the fixed-size predictor used by the five-stage core.
- Tournament branch predictor: per-PC local history predictor plus gshare global predictor, arbitrated by a per-PC chooser.
- Adds a direct-mapped BTB, speculative global history with misprediction restore, and performance counters.
- Predicts combinationally for the IF-stage PC; trains from the ID-stage branch resolution.

Parameters:
- ADDR_W, 32, PC/target width (word-aligned; bits [1:0] ignored).
- GHR_W, 10, global history bits; global PHT has 2^GHR_W entries.
- LHT_IDX_W, 8, local history table index bits, from pc[LHT_IDX_W+1:2].
- LHR_W, 10, local history bits; local PHT has 2^LHR_W entries.
- CHS_IDX_W, 10, chooser table index bits, from pc[CHS_IDX_W+1:2].
- BTB_IDX_W, 6, BTB index bits, from pc[BTB_IDX_W+1:2]; tag is pc[ADDR_W-1:BTB_IDX_W+2].
- CNT_W, 32, performance counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- if_valid  input  1  IF PC valid; not stalled.
- if_pc  input  ADDR_W  fetch PC.
- pred_hit  output  1  BTB hit for if_pc.
- pred_taken  output  1  predicted taken.
- pred_target  output  ADDR_W  next-PC prediction.
- pred_ghr  output  GHR_W  global history snapshot, carried down the pipe.
- pred_lhr  output  LHR_W  local history snapshot, carried down the pipe.
- pred_local  output  1  local component direction.
- pred_global  output  1  global component direction.
- upd_valid  input  1  resolved conditional branch this cycle.
- upd_pc  input  ADDR_W  PC of the resolved branch.
- upd_taken  input  1  actual direction.
- upd_target  input  ADDR_W  actual taken target.
- upd_ghr  input  GHR_W  returned snapshot.
- upd_lhr  input  LHR_W  returned snapshot.
- upd_pred_local  input  1  returned snapshot.
- upd_pred_global  input  1  returned snapshot.
- upd_mispredict  input  1  final prediction was wrong.
- cnt_branch  output  CNT_W  resolved branch count.
- cnt_miss  output  CNT_W  misprediction count.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - GHR=0; all LHT entries=0; all PHT and chooser counters=2'b01; all BTB valid bits=0; counters=0.
  - While rst=0, every prediction output is forced to 0.
- Prediction (combinational, zero latency, reads pre-edge state):
  - pred_hit = BTB valid && tag match.
  - pred_lhr = LHT[idx].
  - pred_local = LPHT[pred_lhr][1].
  - pred_global = GPHT[GHR ^ if_pc[GHR_W+1:2]][1].
  - Chooser selects global when its counter >= 2, otherwise local.
  - pred_taken = pred_hit && chosen bit.
  - pred_target = BTB target when pred_taken, else if_pc+4 (mod 2^ADDR_W).
  - pred_ghr = current GHR.
  - Outputs are valid regardless of if_valid.
- GHR update at each edge, in priority order:
  1. upd_valid && upd_mispredict: GHR <= {upd_ghr[GHR_W-2:0], upd_taken} (restore wins).
  2. if_valid && pred_hit: GHR <= {GHR[GHR_W-2:0], pred_taken}.
  3. Otherwise: hold.
- Training on upd_valid (edge):
  - LPHT[upd_lhr] saturates toward upd_taken (range 0..3).
  - GPHT[upd_ghr ^ upd_pc[GHR_W+1:2]] saturates toward upd_taken.
  - LHT[upd idx] <= {upd_lhr[LHR_W-2:0], upd_taken}.
  - Chooser changes only when upd_pred_local != upd_pred_global: +1 if the global component was correct, -1 if local was correct, saturating 0..3.
  - When upd_taken: BTB[idx] <= {valid=1, tag, upd_target}, overwriting any entry.
  - When not taken: BTB untouched.
- Same-cycle read/write to one entry: prediction sees the old value; no bypass.
- Counters:
  - cnt_branch increments on upd_valid.
  - cnt_miss increments on upd_valid && upd_mispredict.
  - Both wrap at 2^CNT_W.
- Reset asserted mid-operation clears all state immediately; in-flight snapshots returned after reset are trained normally.

Test Plan:
- Hold rst=0 and drive if_pc=0x100 -> all prediction outputs 0. Release rst -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_ghr=0, cnt_branch=0.
- Loop: predict pc 0x100, then update with upd_taken=1, target 0x200, feeding back the snapshots; run LHR_W+2 iterations -> pred_hit=1, pred_taken=1, pred_target=0x200. cnt_branch equals the iteration count; cnt_miss equals the number of mispredicted iterations.
- In one cycle drive if_valid=1 with a BTB hit, plus upd_valid=1, upd_mispredict=1, upd_ghr=10'h155, upd_taken=0 -> next pred_ghr=10'h2AA (restore wins).
- Update with upd_pred_local=upd_pred_global=1 repeatedly -> chooser unchanged. LPHT/GPHT entries stay 2'b11 after further taken updates (saturation).
- BTB alias: allocate pc 0x100 -> 0x200, then predict pc 0x200 (same index for BTB_IDX_W=6, different tag) -> pred_hit=0, pred_target=0x204.
- Pulse rst low between edges after training -> outputs and cnt_miss read 0 before the next clk edge. After release, pc 0x100 misses.
